// File: rtl/conv2d_engine.sv
// conv2d_engine: time-multiplexed conv PE -- NUM_OUT filters over one latched window, LANES MACs per beat,
// then bias/floor/saturate and activation. Define CONV2D_HSWISH_EN to build hard-swish for act_mode=3.
module conv2d_engine #(
    parameter int BITSIZE    = 14,
    parameter int FRAC_BITS  = 7,
    parameter int NUM_INPUTS = 27,
    parameter int NUM_OUT    = 16,
    parameter int LANES      = 9
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [BITSIZE*NUM_INPUTS-1:0]         data_in,
    input  logic [BITSIZE*NUM_INPUTS*NUM_OUT-1:0] weights,
    input  logic [BITSIZE*NUM_OUT-1:0]            bias,
    input  logic [1:0]                            act_mode,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [BITSIZE*NUM_OUT-1:0]            data_out,
    output logic [NUM_OUT-1:0]                    sat_flag
);

    localparam int BEATS  = NUM_INPUTS / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ACC_W  = 2*BITSIZE + $clog2(NUM_INPUTS) + 1;
    localparam int PROD_W = 2*BITSIZE;
    localparam int WIN_W  = BITSIZE*NUM_INPUTS;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};
    localparam logic signed [BITSIZE:0] SIX_C   = (BITSIZE+1)'(32'sd6 * (32'sd1 <<< FRAC_BITS));
`ifdef CONV2D_HSWISH_EN
    localparam int HS_W = 3*BITSIZE + 8;
    localparam logic signed [BITSIZE:0] THREE_C     = (BITSIZE+1)'(32'sd3 * (32'sd1 <<< FRAC_BITS));
    localparam logic signed [HS_W-1:0] ONE_SIXTH_C = HS_W'(((32'sd1 <<< FRAC_BITS) + 32'sd3) / 32'sd6);
    localparam logic signed [HS_W-1:0] HS_MAX      = HS_W'(SAT_MAX);
    localparam logic signed [HS_W-1:0] HS_MIN      = HS_W'(SAT_MIN);
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_POST = 3'd2,
        S_ACT  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      accept_s;
    logic [BEAT_W-1:0]         beat_r;
    logic [WIN_W-1:0]          data_r;
    logic [WIN_W-1:0]          wt_r [NUM_OUT];
    logic [BITSIZE*NUM_OUT-1:0] bias_r;
    logic [1:0]                mode_r;
    logic signed [ACC_W-1:0]   acc_r [NUM_OUT];
    logic signed [ACC_W-1:0]   beat_sum_s [NUM_OUT];
    logic [BITSIZE:0]          post_res_s [NUM_OUT];
    logic [BITSIZE:0]          act_res_s [NUM_OUT];
    logic signed [BITSIZE-1:0] post_v_r [NUM_OUT];
    logic [NUM_OUT-1:0]        post_sat_r;

    function automatic logic signed [PROD_W-1:0] mul_f(
        input logic signed [BITSIZE-1:0] a,
        input logic signed [BITSIZE-1:0] b
    );
        mul_f = PROD_W'(a) * PROD_W'(b);
    endfunction

    // Returns {clamped, value}: bias add, floor shift back to Q format, clamp to BITSIZE.
    function automatic logic [BITSIZE:0] post_f(
        input logic signed [ACC_W-1:0]   acc,
        input logic signed [BITSIZE-1:0] b
    );
        logic signed [ACC_W-1:0] v;
        v = (acc + (ACC_W'(b) <<< FRAC_BITS)) >>> FRAC_BITS;
        if (v > SAT_MAX) begin
            post_f = {1'b1, SAT_MAX[BITSIZE-1:0]};
        end else if (v < SAT_MIN) begin
            post_f = {1'b1, SAT_MIN[BITSIZE-1:0]};
        end else begin
            post_f = {1'b0, v[BITSIZE-1:0]};
        end
    endfunction

    function automatic logic [BITSIZE-1:0] relu6_f(input logic signed [BITSIZE:0] x);
        if (x[BITSIZE]) begin
            relu6_f = '0;
        end else if (x > SIX_C) begin
            relu6_f = SIX_C[BITSIZE-1:0];
        end else begin
            relu6_f = x[BITSIZE-1:0];
        end
    endfunction

`ifdef CONV2D_HSWISH_EN
    function automatic logic [BITSIZE:0] hswish_f(input logic signed [BITSIZE-1:0] v);
        logic signed [BITSIZE:0] r;
        logic signed [HS_W-1:0]  h;
        r = $signed({1'b0, relu6_f((BITSIZE+1)'(v) + THREE_C)});
        h = (HS_W'(v) * HS_W'(r) * ONE_SIXTH_C) >>> (2*FRAC_BITS);
        if (h > HS_MAX) begin
            hswish_f = {1'b1, HS_MAX[BITSIZE-1:0]};
        end else if (h < HS_MIN) begin
            hswish_f = {1'b1, HS_MIN[BITSIZE-1:0]};
        end else begin
            hswish_f = {1'b0, h[BITSIZE-1:0]};
        end
    endfunction
`endif

    // Returns {saturated, value}; only hard-swish can raise the flag here.
    function automatic logic [BITSIZE:0] act_f(
        input logic signed [BITSIZE-1:0] v,
        input logic [1:0]                mode
    );
        case (mode)
            2'd0:    act_f = {1'b0, v};
            2'd1:    act_f = v[BITSIZE-1] ? '0 : {1'b0, v};
            2'd2:    act_f = {1'b0, relu6_f((BITSIZE+1)'(v))};
`ifdef CONV2D_HSWISH_EN
            2'd3:    act_f = hswish_f(v);
`endif
            default: act_f = {1'b0, v};
        endcase
    endfunction

    assign accept_s = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nxt_s = S_MAC;
                else          state_nxt_s = S_IDLE;
            end
            S_MAC: begin
                if (beat_r == LAST_BEAT) state_nxt_s = S_POST;
                else                     state_nxt_s = S_MAC;
            end
            S_POST:  state_nxt_s = S_ACT;
            S_ACT:   state_nxt_s = S_HOLD;
            S_HOLD: begin
                if (out_valid && out_ready) state_nxt_s = S_IDLE;
                else                        state_nxt_s = S_HOLD;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Operand capture; operands shift down each beat so the MAC lanes read fixed positions
    always_ff @(posedge clk) begin
        if (accept_s) begin
            data_r <= data_in;
            bias_r <= bias;
            mode_r <= act_mode;
            for (int o = 0; o < NUM_OUT; o++) begin
                wt_r[o] <= weights[o*WIN_W +: WIN_W];
            end
        end else if (state_r == S_MAC) begin
            data_r <= data_r >> (LANES*BITSIZE);
            for (int o = 0; o < NUM_OUT; o++) begin
                wt_r[o] <= wt_r[o] >> (LANES*BITSIZE);
            end
        end
    end

    // Per-channel sum of this beat's LANES full-width products
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            beat_sum_s[o] = '0;
            for (int l = 0; l < LANES; l++) begin
                beat_sum_s[o] = beat_sum_s[o]
                    + ACC_W'(mul_f(data_r[l*BITSIZE +: BITSIZE], wt_r[o][l*BITSIZE +: BITSIZE]));
            end
        end
    end

    // Post-processing and activation results
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            post_res_s[o] = post_f(acc_r[o], bias_r[o*BITSIZE +: BITSIZE]);
            act_res_s[o]  = act_f(post_v_r[o], mode_r);
        end
    end

    // Handshake flags, accumulators and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            data_out   <= '0;
            sat_flag   <= '0;
            beat_r     <= '0;
            post_sat_r <= '0;
            for (int o = 0; o < NUM_OUT; o++) begin
                acc_r[o]    <= '0;
                post_v_r[o] <= '0;
            end
        end else begin
            in_ready <= (state_nxt_s == S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        beat_r <= '0;
                        for (int o = 0; o < NUM_OUT; o++) begin
                            acc_r[o] <= '0;
                        end
                    end
                end
                S_MAC: begin
                    beat_r <= beat_r + BEAT_ONE;
                    for (int o = 0; o < NUM_OUT; o++) begin
                        acc_r[o] <= acc_r[o] + beat_sum_s[o];
                    end
                end
                S_POST: begin
                    for (int o = 0; o < NUM_OUT; o++) begin
                        post_v_r[o]   <= post_res_s[o][BITSIZE-1:0];
                        post_sat_r[o] <= post_res_s[o][BITSIZE];
                    end
                end
                S_ACT: begin
                    out_valid <= 1'b1;
                    for (int o = 0; o < NUM_OUT; o++) begin
                        data_out[o*BITSIZE +: BITSIZE] <= act_res_s[o][BITSIZE-1:0];
                        sat_flag[o] <= post_sat_r[o] | act_res_s[o][BITSIZE];
                    end
                end
                S_HOLD: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
